video_layer_mixer: RTL and testbench

Parametrised N-layer video compositor that replaces the fixed two-source colour-key mux between the text/tile engine, the Graphite framebuffer stream and the VGA/DVI output. Takes NUM_LAYERS pixel streams aligned to one master timing (hsync/vsync/de) and selects, per pixel, the highest-priority non-transparent layer, falling back to a background colour. Configuration is written through a small register port into shadow registers that take effect atomically at frame start. Timing signals are delayed to match the pixel pipeline.

---
 rtl/video_layer_mixer.sv | 197 +++++++++++++++++++
 tb/tb_video_layer_mixer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/video_layer_mixer.sv
// Prioritised N-layer colour-key compositor with frame-synchronous shadow config.
// Define VIDEO_MIXER_BLEND_EN to build the layer-0 averaging path.
module video_layer_mixer #(
   parameter int NUM_LAYERS = 2,
   parameter int COLOR_BITS = 4
) (
   input  logic                               clk,
   input  logic                               reset_ni,
   input  logic [NUM_LAYERS*3*COLOR_BITS-1:0] layer_rgb_i,
   input  logic                               hsync_i,
   input  logic                               vsync_i,
   input  logic                               de_i,
   input  logic                               cfg_wr_i,
   input  logic [3:0]                         cfg_addr_i,
   input  logic [31:0]                        cfg_data_i,
   output logic [COLOR_BITS-1:0]              r_o,
   output logic [COLOR_BITS-1:0]              g_o,
   output logic [COLOR_BITS-1:0]              b_o,
   output logic                               hsync_o,
   output logic                               vsync_o,
   output logic                               de_o,
   output logic                               cfg_pending_o,
   output logic [15:0]                        frame_count_o
);

   localparam int PW = 3 * COLOR_BITS;
   localparam int DW = (PW > NUM_LAYERS) ? PW : NUM_LAYERS;
   localparam logic [NUM_LAYERS-1:0] KEN_RST =
      NUM_LAYERS'((1 << (NUM_LAYERS - 1)) - 1);

   typedef logic [PW-1:0] pix_t;

   logic [NUM_LAYERS-1:0] en_sh, en_ac, en_nx;
   logic [NUM_LAYERS-1:0] ken_sh, ken_ac, ken_nx;
   pix_t                  bg_sh, bg_ac, bg_nx;
   pix_t                  key_sh [NUM_LAYERS];
   pix_t                  key_ac [NUM_LAYERS];
   pix_t                  key_nx [NUM_LAYERS];

   logic                  vsync_q;
   logic                  frame_start;
   logic                  cfg_hit;
   logic                  cfg_unused;

   logic [NUM_LAYERS-1:0] tr_nx, tr_s1;
   pix_t                  pix_s1 [NUM_LAYERS];
   pix_t                  bg_s1;
   logic                  hs_s1, vs_s1, de_s1;

   pix_t                  below, mix, blended, rgb_q;

`ifdef VIDEO_MIXER_BLEND_EN
   logic                  blend_sh, blend_ac, blend_s1;
   logic [COLOR_BITS:0]   sum;
`endif

   assign frame_start = vsync_q & ~vsync_i;
   assign cfg_hit     = cfg_wr_i &&
                        ({28'd0, cfg_addr_i} < 32'(NUM_LAYERS + 2));
   assign cfg_unused  = ^cfg_data_i[30:DW];

   always_ff @(posedge clk or negedge reset_ni) begin
      if (!reset_ni) begin
         en_sh  <= '1;
         ken_sh <= KEN_RST;
         bg_sh  <= '0;
         for (int l = 0; l < NUM_LAYERS; l++) key_sh[l] <= '0;
`ifdef VIDEO_MIXER_BLEND_EN
         blend_sh <= 1'b0;
`endif
      end else if (cfg_wr_i) begin
         if (cfg_addr_i == 4'd0) begin
            en_sh <= cfg_data_i[NUM_LAYERS-1:0];
`ifdef VIDEO_MIXER_BLEND_EN
            blend_sh <= cfg_data_i[31];
`endif
         end
         if (cfg_addr_i == 4'd1) bg_sh <= cfg_data_i[PW-1:0];
         for (int l = 0; l < NUM_LAYERS; l++) begin
            if (cfg_addr_i == 4'(l + 2)) begin
               key_sh[l] <= cfg_data_i[PW-1:0];
               ken_sh[l] <= cfg_data_i[31];
            end
         end
      end
   end

   // Active set swaps in on the vsync falling edge only.
   always_ff @(posedge clk or negedge reset_ni) begin
      if (!reset_ni) begin
         en_ac         <= '1;
         ken_ac        <= KEN_RST;
         bg_ac         <= '0;
         for (int l = 0; l < NUM_LAYERS; l++) key_ac[l] <= '0;
         vsync_q       <= 1'b1;
         frame_count_o <= '0;
         cfg_pending_o <= 1'b0;
`ifdef VIDEO_MIXER_BLEND_EN
         blend_ac <= 1'b0;
`endif
      end else begin
         vsync_q <= vsync_i;
         if (frame_start) begin
            en_ac         <= en_sh;
            ken_ac        <= ken_sh;
            bg_ac         <= bg_sh;
            for (int l = 0; l < NUM_LAYERS; l++) key_ac[l] <= key_sh[l];
            frame_count_o <= frame_count_o + 16'd1;
`ifdef VIDEO_MIXER_BLEND_EN
            blend_ac <= blend_sh;
`endif
         end
         if (cfg_hit)          cfg_pending_o <= 1'b1;
         else if (frame_start) cfg_pending_o <= 1'b0;
      end
   end

   // The pixel sampled on the apply cycle already sees the new set.
   always_comb begin
      en_nx  = frame_start ? en_sh  : en_ac;
      ken_nx = frame_start ? ken_sh : ken_ac;
      bg_nx  = frame_start ? bg_sh  : bg_ac;
      tr_nx  = '0;
      for (int l = 0; l < NUM_LAYERS; l++) begin
         key_nx[l] = frame_start ? key_sh[l] : key_ac[l];
         tr_nx[l]  = !en_nx[l] ||
                     (ken_nx[l] && layer_rgb_i[l*PW +: PW] == key_nx[l]);
      end
   end

   always_ff @(posedge clk or negedge reset_ni) begin
      if (!reset_ni) begin
         for (int l = 0; l < NUM_LAYERS; l++) pix_s1[l] <= '0;
         tr_s1 <= '1;
         bg_s1 <= '0;
         hs_s1 <= 1'b1;
         vs_s1 <= 1'b1;
         de_s1 <= 1'b0;
`ifdef VIDEO_MIXER_BLEND_EN
         blend_s1 <= 1'b0;
`endif
      end else begin
         for (int l = 0; l < NUM_LAYERS; l++)
            pix_s1[l] <= layer_rgb_i[l*PW +: PW];
         tr_s1 <= tr_nx;
         bg_s1 <= bg_nx;
         hs_s1 <= hsync_i;
         vs_s1 <= vsync_i;
         de_s1 <= de_i;
`ifdef VIDEO_MIXER_BLEND_EN
         blend_s1 <= frame_start ? blend_sh : blend_ac;
`endif
      end
   end

   always_comb begin
      below = bg_s1;
      for (int l = NUM_LAYERS - 1; l >= 1; l--)
         if (!tr_s1[l]) below = pix_s1[l];
      mix = tr_s1[0] ? below : pix_s1[0];
   end

`ifdef VIDEO_MIXER_BLEND_EN
   always_comb begin
      blended = mix;
      sum     = '0;
      if (blend_s1 && !tr_s1[0]) begin
         for (int c = 0; c < 3; c++) begin
            sum = {1'b0, pix_s1[0][c*COLOR_BITS +: COLOR_BITS]} +
                  {1'b0, below[c*COLOR_BITS +: COLOR_BITS]};
            blended[c*COLOR_BITS +: COLOR_BITS] = COLOR_BITS'(sum >> 1);
         end
      end
   end
`else
   assign blended = mix;
`endif

   always_ff @(posedge clk or negedge reset_ni) begin
      if (!reset_ni) begin
         rgb_q   <= '0;
         hsync_o <= 1'b1;
         vsync_o <= 1'b1;
         de_o    <= 1'b0;
      end else begin
         rgb_q   <= de_s1 ? blended : '0;
         hsync_o <= hs_s1;
         vsync_o <= vs_s1;
         de_o    <= de_s1;
      end
   end

   assign r_o = rgb_q[3*COLOR_BITS-1 -: COLOR_BITS];
   assign g_o = rgb_q[2*COLOR_BITS-1 -: COLOR_BITS];
   assign b_o = rgb_q[COLOR_BITS-1:0];

endmodule

// File: tb/tb_video_layer_mixer.sv
// Scoreboard bench for video_layer_mixer, four 12-bit layers.
module tb_video_layer_mixer;

   logic        clk = 1'b0;
   logic        reset_ni;
   logic [47:0] layer_rgb_i;
   logic        hsync_i, vsync_i, de_i;
   logic        cfg_wr_i;
   logic [3:0]  cfg_addr_i;
   logic [31:0] cfg_data_i;
   logic [3:0]  r_o, g_o, b_o;
   logic        hsync_o, vsync_o, de_o;
   logic        cfg_pending_o;
   logic [15:0] frame_count_o;

`ifdef VIDEO_MIXER_BLEND_EN
   localparam bit BL = 1'b1;
`else
   localparam bit BL = 1'b0;
`endif

   typedef struct {
      int         due;
      int         id;
      logic [11:0] rgb;
      logic       hs;
      logic       vs;
      logic       de;
   } exp_t;

   exp_t q[$];
   exp_t ev;
   int   n    = 0;
   int   vid  = 0;
   int   nvec = 0;
   int   nerr = 0;

   video_layer_mixer #(.NUM_LAYERS(4), .COLOR_BITS(4)) dut (
      .clk(clk), .reset_ni(reset_ni), .layer_rgb_i(layer_rgb_i),
      .hsync_i(hsync_i), .vsync_i(vsync_i), .de_i(de_i),
      .cfg_wr_i(cfg_wr_i), .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i),
      .r_o(r_o), .g_o(g_o), .b_o(b_o),
      .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o),
      .cfg_pending_o(cfg_pending_o), .frame_count_o(frame_count_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) n <= n + 1;

   always @(negedge clk) begin
      while (q.size() != 0 && q[0].due <= n) begin
         ev = q.pop_front();
         nvec++;
         if ({r_o, g_o, b_o, hsync_o, vsync_o, de_o} !==
             {ev.rgb, ev.hs, ev.vs, ev.de}) begin
            nerr++;
            $display("FAIL vec%0d: got rgb=%h hs/vs/de=%b%b%b, want rgb=%h %b%b%b",
                     ev.id, {r_o, g_o, b_o}, hsync_o, vsync_o, de_o,
                     ev.rgb, ev.hs, ev.vs, ev.de);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   task automatic step(input logic [11:0] l0, l1, l2, l3,
                       input logic hs, vs, en,
                       input logic wr, input logic [3:0] a,
                       input logic [31:0] d, input logic [11:0] want);
      exp_t e;
      layer_rgb_i = {l3, l2, l1, l0};
      hsync_i     = hs;
      vsync_i     = vs;
      de_i        = en;
      cfg_wr_i    = wr;
      cfg_addr_i  = a;
      cfg_data_i  = d;
      e.due = n + 2;
      e.id  = vid++;
      e.rgb = en ? want : 12'h000;
      e.hs  = hs;
      e.vs  = vs;
      e.de  = en;
      q.push_back(e);
      @(negedge clk);
   endtask

   task automatic px(input logic [11:0] l0, l1, l2, l3,
                     input logic vs, input logic [11:0] want);
      step(l0, l1, l2, l3, 1'b1, vs, 1'b1, 1'b0, 4'd0, 32'd0, want);
   endtask

   task automatic wp(input logic [3:0] a, input logic [31:0] d,
                     input logic [11:0] l0, l1, input logic vs,
                     input logic [11:0] want);
      step(l0, l1, 12'h000, 12'h000, 1'b1, vs, 1'b1, 1'b1, a, d, want);
   endtask

   task automatic chk_rst(input string nm);
      chk({nm, "_rgb"},  {20'd0, r_o, g_o, b_o}, 32'h0);
      chk({nm, "_sync"}, {29'd0, hsync_o, vsync_o, de_o}, 32'h6);
      chk({nm, "_pend"}, {31'd0, cfg_pending_o}, 32'h0);
      chk({nm, "_fc"},   {16'd0, frame_count_o}, 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_ni    = 1'b0;
      layer_rgb_i = '0;
      hsync_i     = 1'b1;
      vsync_i     = 1'b1;
      de_i        = 1'b0;
      cfg_wr_i    = 1'b0;
      cfg_addr_i  = '0;
      cfg_data_i  = '0;
      repeat (2) @(negedge clk);
      chk_rst("reset");
      reset_ni = 1'b1;

      // legacy black-is-transparent defaults, layer 3 unkeyed
      px(12'h000, 12'h5A3, 12'h000, 12'h000, 1'b1, 12'h5A3);
      px(12'h123, 12'h5A3, 12'h000, 12'h000, 1'b1, 12'h123);
      px(12'h000, 12'h000, 12'h000, 12'hABC, 1'b1, 12'hABC);
      px(12'h000, 12'h000, 12'h000, 12'h000, 1'b1, 12'h000);

      wp(4'd0, 32'h1, 12'h000, 12'h5A3, 1'b1, 12'h5A3);
      chk("pend_after_wr", {31'd0, cfg_pending_o}, 32'h1);
      px(12'h000, 12'h5A3, 12'h000, 12'h000, 1'b1, 12'h5A3);
      wp(4'd1, 32'h246, 12'h000, 12'h5A3, 1'b1, 12'h5A3);
      wp(4'd15, 32'hFFF, 12'h000, 12'h5A3, 1'b1, 12'h5A3);
      px(12'h000, 12'h5A3, 12'h000, 12'hABC, 1'b0, 12'h246);
      chk("pend_applied", {31'd0, cfg_pending_o}, 32'h0);
      chk("fc_1", {16'd0, frame_count_o}, 32'h1);
      px(12'h777, 12'h5A3, 12'h000, 12'h000, 1'b0, 12'h777);
      px(12'h000, 12'h5A3, 12'h000, 12'h000, 1'b1, 12'h246);

      // key write coincides with frame start: deferred one frame
      wp(4'd2, 32'h80000F00, 12'h000, 12'h5A3, 1'b0, 12'h246);
      chk("pend_same_cycle", {31'd0, cfg_pending_o}, 32'h1);
      chk("fc_2", {16'd0, frame_count_o}, 32'h2);
      px(12'hF00, 12'h000, 12'h000, 12'h000, 1'b0, 12'hF00);
      px(12'h000, 12'h000, 12'h000, 12'h000, 1'b1, 12'h246);
      px(12'hF00, 12'h000, 12'h000, 12'h000, 1'b0, 12'h246);
      chk("pend_deferred", {31'd0, cfg_pending_o}, 32'h0);
      chk("fc_3", {16'd0, frame_count_o}, 32'h3);
      px(12'h000, 12'h5A3, 12'h000, 12'h000, 1'b0, 12'h000);
      px(12'h000, 12'h000, 12'h000, 12'h000, 1'b1, 12'h000);

      // every layer keyed on black, green background
      wp(4'd0, 32'hF, 12'h000, 12'h000, 1'b1, 12'h000);
      wp(4'd2, 32'h80000000, 12'h000, 12'h000, 1'b1, 12'h000);
      wp(4'd3, 32'h80000000, 12'h000, 12'h000, 1'b1, 12'h000);
      wp(4'd4, 32'h80000000, 12'h000, 12'h000, 1'b1, 12'h000);
      wp(4'd5, 32'h80000000, 12'h000, 12'h000, 1'b1, 12'h000);
      wp(4'd1, 32'h0F0, 12'h000, 12'h000, 1'b1, 12'h000);
      px(12'h000, 12'h000, 12'h000, 12'h000, 1'b0, 12'h0F0);
      step(12'h000, 12'h000, 12'h000, 12'h000, 1'b1, 1'b0, 1'b0,
           1'b0, 4'd0, 32'd0, 12'h000);
      step(12'h123, 12'h000, 12'h000, 12'h000, 1'b0, 1'b0, 1'b0,
           1'b0, 4'd0, 32'd0, 12'h000);
      step(12'h000, 12'h000, 12'h000, 12'h000, 1'b0, 1'b1, 1'b0,
           1'b0, 4'd0, 32'd0, 12'h000);
      step(12'h000, 12'h000, 12'h000, 12'h000, 1'b1, 1'b1, 1'b1,
           1'b0, 4'd0, 32'd0, 12'h0F0);
      px(12'h000, 12'h000, 12'h777, 12'h000, 1'b1, 12'h777);
      px(12'h000, 12'h000, 12'h000, 12'h5A3, 1'b1, 12'h5A3);

      // averaging of layer 0 with what lies beneath it
      wp(4'd0, 32'h8000000F, 12'h000, 12'h000, 1'b1, 12'h0F0);
      px(12'hF00, 12'h0F0, 12'h000, 12'h000, 1'b0,
         BL ? 12'h770 : 12'hF00);
      px(12'hE42, 12'h000, 12'h000, 12'h000, 1'b0,
         BL ? 12'h791 : 12'hE42);
      px(12'h000, 12'h0A0, 12'h000, 12'h000, 1'b0, 12'h0A0);
      px(12'hF00, 12'h000, 12'h000, 12'h0F0, 1'b0,
         BL ? 12'h770 : 12'hF00);
      chk("fc_5", {16'd0, frame_count_o}, 32'h5);

      // asynchronous reset in the middle of a line
      wp(4'd1, 32'hABC, 12'h000, 12'h000, 1'b1, 12'h0F0);
      cfg_wr_i = 1'b0;
      chk("pend_pre_rst", {31'd0, cfg_pending_o}, 32'h1);
      px(12'h321, 12'h000, 12'h000, 12'h000, 1'b1, 12'h321);
      #2 reset_ni = 1'b0;
      #1 chk_rst("midrst");
      q.delete();
      @(negedge clk);
      @(negedge clk);
      reset_ni = 1'b1;
      px(12'h000, 12'h5A3, 12'h000, 12'h000, 1'b1, 12'h5A3);
      px(12'hF00, 12'h0F0, 12'h000, 12'h000, 1'b1, 12'hF00);
      px(12'h000, 12'h000, 12'h000, 12'h000, 1'b1, 12'h000);
      chk("fc_post_rst", {16'd0, frame_count_o}, 32'h0);

      repeat (4) @(negedge clk);
      chk("drain", q.size(), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
